// File: rtl/spw_rx_char_decoder.sv
// SpaceWire receive character decoder: hunts for the first NULL, then checks odd
// parity and turns each character into one-cycle data/control/time-code strobes.
module spw_rx_char_decoder (
    input  logic       negedge_clk,
    input  logic       rx_reset,
    input  logic       rx_din,
    input  logic       rx_din_valid,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic [7:0] rx_timecode,
    output logic       rx_tick,
    output logic       rx_fct,
    output logic       rx_eop,
    output logic       rx_eep,
    output logic       rx_null,
    output logic       rx_null_seen,
    output logic       rx_parity_error,
    output logic       rx_esc_error
);

    typedef enum logic [2:0] {
        HUNT,
        PARITY,
        FLAG,
        CTRL,
        DATA
    } state_t;

    // ESC flag+payload, FCT parity, FCT flag+payload, oldest bit in the MSB
    localparam logic [6:0] SYNC_PAT = 7'b1110100;

    state_t     state_q;
    logic [6:0] sr_q;
    logic       acc_q;
    logic       par_q;
    logic       esc_pending_q;
    logic [2:0] cnt_q;
    logic       ctrl_first_q;
    logic [7:0] shift_q;

    logic [7:0] rx_data_q;
    logic [7:0] rx_timecode_q;
    logic       data_valid_q;
    logic       tick_q;
    logic       fct_q;
    logic       eop_q;
    logic       eep_q;
    logic       null_q;
    logic       null_seen_q;
    logic       parity_error_q;
    logic       esc_error_q;

    logic [6:0] sr_d;
    logic [7:0] shift_d;
    logic       acc_d;

    assign sr_d    = {sr_q[5:0], rx_din};
    assign shift_d = {rx_din, shift_q[7:1]};
    assign acc_d   = acc_q ^ rx_din;

    function automatic logic parity_ok(input logic p, input logic f, input logic acc);
        return (p ^ f ^ acc) == 1'b1;
    endfunction

    always_ff @(posedge negedge_clk) begin
        if (rx_reset) begin
            state_q        <= HUNT;
            sr_q           <= '0;
            acc_q          <= 1'b0;
            par_q          <= 1'b0;
            esc_pending_q  <= 1'b0;
            cnt_q          <= '0;
            ctrl_first_q   <= 1'b0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_timecode_q  <= '0;
            data_valid_q   <= 1'b0;
            tick_q         <= 1'b0;
            fct_q          <= 1'b0;
            eop_q          <= 1'b0;
            eep_q          <= 1'b0;
            null_q         <= 1'b0;
            null_seen_q    <= 1'b0;
            parity_error_q <= 1'b0;
            esc_error_q    <= 1'b0;
        end else begin
            data_valid_q   <= 1'b0;
            tick_q         <= 1'b0;
            fct_q          <= 1'b0;
            eop_q          <= 1'b0;
            eep_q          <= 1'b0;
            null_q         <= 1'b0;
            parity_error_q <= 1'b0;
            esc_error_q    <= 1'b0;
            if (rx_din_valid) begin
                case (state_q)
                    HUNT: begin
                        sr_q <= sr_d;
                        if (sr_d == SYNC_PAT) begin
                            null_q      <= 1'b1;
                            null_seen_q <= 1'b1;
                            acc_q       <= 1'b0;
                            state_q     <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= rx_din;
                        state_q <= FLAG;
                    end
                    FLAG: begin
                        if (!parity_ok(par_q, rx_din, acc_q)) begin
                            parity_error_q <= 1'b1;
                            null_seen_q    <= 1'b0;
                            esc_pending_q  <= 1'b0;
                            sr_q           <= '0;
                            state_q        <= HUNT;
                        end else begin
                            acc_q   <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= rx_din ? CTRL : DATA;
                        end
                    end
                    CTRL: begin
                        acc_q <= acc_d;
                        if (cnt_q == 3'd0) begin
                            ctrl_first_q <= rx_din;
                            cnt_q        <= 3'd1;
                        end else begin
                            state_q <= PARITY;
                            // Codes are in wire order: FCT=0,0 EOP=0,1 EEP=1,0 ESC=1,1
                            if (!esc_pending_q) begin
                                case ({ctrl_first_q, rx_din})
                                    2'b00:   fct_q         <= 1'b1;
                                    2'b01:   eop_q         <= 1'b1;
                                    2'b10:   eep_q         <= 1'b1;
                                    default: esc_pending_q <= 1'b1;
                                endcase
                            end else begin
                                esc_pending_q <= 1'b0;
                                if ({ctrl_first_q, rx_din} == 2'b00) begin
                                    null_q <= 1'b1;
                                end else begin
                                    esc_error_q <= 1'b1;
                                    null_seen_q <= 1'b0;
                                    sr_q        <= '0;
                                    state_q     <= HUNT;
                                end
                            end
                        end
                    end
                    DATA: begin
                        acc_q   <= acc_d;
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q       <= PARITY;
                            esc_pending_q <= 1'b0;
                            if (esc_pending_q) begin
                                rx_timecode_q <= shift_d;
                                tick_q        <= 1'b1;
                            end else begin
                                rx_data_q    <= shift_d;
                                data_valid_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign rx_data         = rx_data_q;
    assign rx_data_valid   = data_valid_q;
    assign rx_timecode     = rx_timecode_q;
    assign rx_tick         = tick_q;
    assign rx_fct          = fct_q;
    assign rx_eop          = eop_q;
    assign rx_eep          = eep_q;
    assign rx_null         = null_q;
    assign rx_null_seen    = null_seen_q;
    assign rx_parity_error = parity_error_q;
    assign rx_esc_error    = esc_error_q;

endmodule

// File: doc/spw_rx_char_decoder.md
# spw_rx_char_decoder

Receive-side character decoder for the SpaceWire link layer (ECSS-E-ST-50-12C). It consumes the serial bit stream recovered from Data/Strobe, one bit per qualified cycle. It then acquires character sync on the first NULL, checks odd parity and decodes each character into data bytes, FCT, EOP, EEP, NULL and time-codes as one-cycle strobes. It sits directly downstream of the DS bit-recovery / bit-position stage in the negedge receive clock domain and feeds the receive FIFO and the link-state FSM.

## Interface
- No parameters.
- negedge_clk  in  1  receive clock; all logic on its rising edge.
- rx_reset  in  1  synchronous, active-high reset.
- rx_din  in  1  recovered serial bit.
- rx_din_valid  in  1  qualifies rx_din. Bits are consumed only when this is 1.
- rx_data  out  8  decoded data byte; valid with rx_data_valid.
- rx_data_valid  out  1  one-cycle strobe.
- rx_timecode  out  8  time-code byte; valid with rx_tick.
- rx_tick  out  1  one-cycle strobe.
- rx_fct, rx_eop, rx_eep, rx_null  out  1 each  one-cycle strobes.
- rx_null_seen  out  1  level: character sync acquired.
- rx_parity_error  out  1  one-cycle strobe.
- rx_esc_error  out  1  one-cycle strobe.

## Operation
- Wire format:
  - Characters are sent as parity bit P, then flag F, then payload LSB first.
  - F=1: 2-bit control code. FCT=00, EOP=01, EEP=10, ESC=11.
  - F=0: 8-bit data.
- Odd parity: XOR(previous char payload bits, P, F) must equal 1.
- States are HUNT, PARITY, FLAG, CTRL (2 bits), DATA (8 bits). Every transition and shift happens only on a cycle with rx_din_valid=1.
- HUNT:
  - 7-bit shift register, sr <= {sr[5:0], rx_din}.
  - When sr matches 7'b1110100 (ESC flag and payload, P, FCT flag and payload), then:
    - pulse rx_null,
    - set rx_null_seen=1,
    - preset the parity accumulator to 0 (the FCT payload),
    - go to PARITY.
  - No other outputs are produced in HUNT.
- PARITY: latch P, go to FLAG.
- FLAG: check P^F^acc.
  - On fail: pulse rx_parity_error, clear rx_null_seen and esc_pending, go to HUNT.
  - Otherwise go to CTRL if F=1, or DATA if F=0.
- CTRL / DATA:
  - Shift payload LSB-first and accumulate its XOR into acc.
  - After the last bit, decode, then go to PARITY.
- Decode, esc_pending clear:
  - FCT → rx_fct.
  - EOP → rx_eop.
  - EEP → rx_eep.
  - ESC → set esc_pending, no strobe.
  - data → rx_data and rx_data_valid.
- Decode, esc_pending set (always clears esc_pending):
  - FCT → rx_null.
  - data → rx_timecode and rx_tick.
  - ESC/EOP/EEP → rx_esc_error, clear rx_null_seen, go to HUNT.
- At most one strobe is asserted per cycle.
- Reset values:
  - all strobes 0, rx_data=0, rx_timecode=0, rx_null_seen=0;
  - state=HUNT, sr=0, acc=0, esc_pending=0.

## Timing
- Strobes rise in the cycle after the edge that sampled the character's last bit, and are high for exactly one cycle. rx_din_valid=0 in that next cycle does not stretch or delay them.
- rx_data and rx_timecode hold their last value until the next strobe of the same kind.
- rx_null_seen rises together with the sync rx_null strobe. It falls one cycle after the sampling edge that caused an error.
- Minimum character spacing: 4 valid bits for control, 10 for data. Back-to-back characters must decode without lost bits.
- rx_din_valid=0 freezes all state, sr and acc; a gap of any length mid-character is legal.
- rx_reset=1 on any edge overrides everything, including mid-character, and outputs take reset values on the next cycle.

## Test plan
- Sync: after reset, send 0,1,1,1,0,1,0,0 → single rx_null pulse after the 8th valid bit; rx_null_seen=1.
- Data: after sync, send 1,0,1,0,1,0,0,1,0,1 → rx_data=8'hA5 with one rx_data_valid pulse.
- Time-code: after sync, send ESC (0,1,1,1) then data 0x2A with correct parity (P=1, F=0) → rx_tick, rx_timecode=8'h2A; no rx_data_valid.
- Parity error: after sync, send FCT with P flipped → rx_parity_error pulse; rx_null_seen=0; a following NULL re-syncs.
- Escape error: ESC followed by EOP, correct parities → rx_esc_error; state HUNT; no rx_eop.
- Gaps and reset: data byte with rx_din_valid toggling every other cycle → same rx_data as without gaps. Asserting rx_reset mid-byte → all outputs at reset values next cycle, and no strobe for the partial byte.
